// File: rtl/logisim_demo_pkg.sv
// logisim_demo_pkg: shared widths and io bit positions for the Tiny Tapeout style
// up/down counter. Optional heartbeat divider is enabled by LOGISIM_DEMO_HEARTBEAT_EN.
package logisim_demo_pkg;

    // Counter width; the io bit mapping below assumes 4.
    localparam int CNT_W     = 4;
    localparam int LDVAL_W   = 3;
    localparam int HB_W      = 2;

    // io_in bit positions
    localparam int CLK_BIT   = 0;
    localparam int RST_BIT   = 1;
    localparam int DOWN_BIT  = 2;
    localparam int HOLD_BIT  = 3;
    localparam int LOAD_BIT  = 4;
    localparam int LDVAL_LSB = 5;

    // io_out bit positions
    localparam int CNT_LSB   = 0;
    localparam int TC_BIT    = 4;
    localparam int OVF_BIT   = 5;
    localparam int HB_LSB    = 6;

    // Terminal count: the value from which the next step in the current direction wraps.
    function automatic logic terminal_count(input logic [CNT_W-1:0] count, input logic down);
        return down ? (count == '0) : (&count);
    endfunction

endpackage

// File: rtl/logisim_demo_counter.sv
// logisim_demo_counter: 4-bit up/down counter with load, hold, sticky overflow and
// combinational terminal count. Discrete clock and asynchronous active-high reset.
module logisim_demo_counter
    import logisim_demo_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_down,
    input  logic               i_hold,
    input  logic               i_load,
    input  logic [LDVAL_W-1:0] i_ldval,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_tc,
    output logic               o_ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    // Count register and sticky overflow; priority reset > load > hold > count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_load) begin
            r_count <= {1'b0, i_ldval};
            r_ovf   <= 1'b0;
        end else if (!i_hold) begin
            if (i_down) begin
                r_count <= r_count - CNT_W'(1);
                if (r_count == '0) r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
                if (&r_count) r_ovf <= 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    // Terminal count looks only at direction and count, not at hold or load.
    assign o_tc    = terminal_count(r_count, i_down);

endmodule

// File: rtl/logisim_demo_top.sv
// logisim_demo_top: packed io wrapper around the up/down counter. Clock and reset
// arrive on io_in bits. Define LOGISIM_DEMO_HEARTBEAT_EN to add a 2-bit clock divider
// on io_out[7:6]; otherwise those bits are tied low and no divider flops exist.
module logisim_demo_top
    import logisim_demo_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic               w_clk;
    logic               w_rst;
    logic               w_down;
    logic               w_hold;
    logic               w_load;
    logic [LDVAL_W-1:0] w_ldval;
    logic [CNT_W-1:0]   w_count;
    logic               w_tc;
    logic               w_ovf;
    logic [HB_W-1:0]    w_hb;

    assign w_clk   = io_in[CLK_BIT];
    assign w_rst   = io_in[RST_BIT];
    assign w_down  = io_in[DOWN_BIT];
    assign w_hold  = io_in[HOLD_BIT];
    assign w_load  = io_in[LOAD_BIT];
    assign w_ldval = io_in[LDVAL_LSB +: LDVAL_W];

    logisim_demo_counter u_counter (
        .i_clk   (w_clk),
        .i_rst   (w_rst),
        .i_down  (w_down),
        .i_hold  (w_hold),
        .i_load  (w_load),
        .i_ldval (w_ldval),
        .o_count (w_count),
        .o_tc    (w_tc),
        .o_ovf   (w_ovf)
    );

`ifdef LOGISIM_DEMO_HEARTBEAT_EN
    logic [HB_W-1:0] r_hb;

    // Free-running divider; ignores hold and load so it always shows the clock is alive.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_hb <= '0;
        else       r_hb <= r_hb + HB_W'(1);
    end

    assign w_hb = r_hb;
`else
    assign w_hb = '0;
`endif

    assign io_out[CNT_LSB +: CNT_W] = w_count;
    assign io_out[TC_BIT]           = w_tc;
    assign io_out[OVF_BIT]          = w_ovf;
    assign io_out[HB_LSB +: HB_W]   = w_hb;

endmodule

// File: tb/tb_logisim_demo_top.sv
// Scoreboard bench for logisim_demo_top: stimulus pushes expected io_out values,
// a monitor pops and compares one entry after each clock edge or async-reset probe.
module tb_logisim_demo_top;

    logic       clk;
    logic       rst;
    logic       down;
    logic       hold;
    logic       load;
    logic [2:0] ldval;
    logic [7:0] io_in;
    logic [7:0] io_out;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] hb_m    = 2'b00;
    event       ev_async;

    assign io_in = {ldval, load, hold, down, rst, clk};

    logisim_demo_top dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Build expected io_out for the current direction and push it.
    task automatic push(input logic [3:0] ec, input logic eo, input string name);
        exp_t       e;
        logic       etc;
        logic [1:0] ehb;
        etc = down ? (ec == 4'd0) : (ec == 4'd15);
`ifdef LOGISIM_DEMO_HEARTBEAT_EN
        ehb = hb_m;
`else
        ehb = 2'b00;
`endif
        e.exp  = {ehb, eo, etc, ec};
        e.name = name;
        q.push_back(e);
    endtask

    // Drive inputs on the falling edge, queue the value expected after the next rising edge.
    task automatic step(input logic r, input logic d, input logic h, input logic l,
                        input logic [2:0] lv, input logic [3:0] ec, input logic eo,
                        input string name);
        @(negedge clk);
        rst = r; down = d; hold = h; load = l; ldval = lv;
        if (r) hb_m = 2'b00;
        else   hb_m = hb_m + 2'd1;
        push(ec, eo, name);
        @(posedge clk);
    endtask

    // Monitor: compare after each rising edge and after an async-reset probe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_async);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (io_out !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: io_out=%b expected %b at %0t", e.name, io_out, e.exp, $time);
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, queue=%0d", q.size());
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        rst = 1'b1; down = 1'b0; hold = 1'b0; load = 1'b0; ldval = 3'b000;

        // Reset held for two edges
        step(1, 0, 0, 0, 3'b000, 4'd0, 1'b0, "reset");
        step(1, 0, 0, 0, 3'b000, 4'd0, 1'b0, "reset");

        // Count up through the wrap: 1..15,0..4; ovf sets on 15->0
        for (int i = 1; i <= 20; i++)
            step(0, 0, 0, 0, 3'b000, 4'(i), (i >= 16), "count_up");

        // Load 5 clears ovf, then counting continues
        step(0, 0, 0, 1, 3'b101, 4'd5, 1'b0, "load");
        for (int i = 6; i <= 9; i++)
            step(0, 0, 0, 0, 3'b000, 4'(i), 1'b0, "count_after_load");

        // Async reset between edges at count 9
        @(negedge clk);
        rst = 1'b1;
        #1;
        hb_m = 2'b00;
        push(4'd0, 1'b0, "async_rst");
        -> ev_async;

        step(1, 0, 0, 0, 3'b000, 4'd0, 1'b0, "rst_held");
        step(0, 0, 0, 0, 3'b000, 4'd1, 1'b0, "count_after_rst");
        step(0, 0, 0, 0, 3'b000, 4'd2, 1'b0, "count_after_rst");

        // Hold at 2 for three edges
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 3'b000, 4'd2, 1'b0, "hold");

        // Count down 1,0,15; tc at 0, ovf on 0->15
        step(0, 1, 0, 0, 3'b000, 4'd1,  1'b0, "down");
        step(0, 1, 0, 0, 3'b000, 4'd0,  1'b0, "down_tc");
        step(0, 1, 0, 0, 3'b000, 4'd15, 1'b1, "down_wrap");
        step(0, 1, 0, 0, 3'b000, 4'd14, 1'b1, "down_sticky");

        // Priority: load over hold, reset over load
        step(0, 1, 1, 1, 3'b011, 4'd3, 1'b0, "load_over_hold");
        step(1, 0, 0, 1, 3'b111, 4'd0, 1'b0, "rst_over_load");
        step(0, 0, 0, 0, 3'b000, 4'd1, 1'b0, "after_rst");
        step(0, 1, 0, 0, 3'b000, 4'd0, 1'b0, "dir_change");

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
